gowin_sdpb_ram: RTL and testbench
=================================

GOWIN_SDPB_RAM -- requirements
Module: gowin_sdpb_ram

Interface
REQ-001 Parameter ADDR_W, default 15, address width; depth = 2**ADDR_W = 32768 words.
REQ-002 Parameter DATA_W, default 2, word width (one pixel, 2 bpp).
REQ-003 Parameter READ_MODE, default 0; 0 = bypass (1-cycle read), 1 = pipeline (2-cycle read, output register gated by oce).
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  single clock for write port A and read port B; all logic samples on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low block reset.
REQ-007 cea  input  1  port A write enable; a write occurs on each rising edge where cea=1.
REQ-008 reseta  input  1  port A synchronous reset, active-high; no effect on memory contents or dout.
REQ-009 ada  input  ADDR_W  write address.
REQ-010 din  input  DATA_W  write data.
REQ-011 ceb  input  1  port B read enable.
REQ-012 resetb  input  1  port B synchronous reset, active-high; clears the read registers.
REQ-013 oce  input  1  output register clock enable; used only when READ_MODE=1.
REQ-014 adb  input  ADDR_W  read address.
REQ-015 dout  output  DATA_W  read data.

Function
REQ-016 Write: at a rising edge with cea=1, mem[ada] <= din; cea=0 leaves memory unchanged.
REQ-017 Every ADDR_W-bit address is valid; no wrap or range check is required.
REQ-018 Read stage: at a rising edge with ceb=1, rd_q <= mem[adb]; ceb=0 holds rd_q.
REQ-019 READ_MODE=0: dout = rd_q; latency is 1 cycle from the address edge, and oce is ignored.
REQ-020 READ_MODE=1: at a rising edge with oce=1, out_q <= rd_q; dout = out_q; latency is 2 cycles with oce held high.
REQ-021 Read-during-write to the same address in the same cycle returns the old data (read-before-write); the new data is visible on the next read.
REQ-022 resetb=1 at a rising edge clears rd_q and out_q to 0, overriding ceb and oce; memory is untouched.
REQ-023 Simultaneous cea and ceb at different addresses are fully independent.
REQ-024 Memory array contents initialise to all zeros at power-up or configuration.

Reset
REQ-025 reset low asynchronously clears rd_q and out_q, so dout = 0 immediately.
REQ-026 reset low blocks writes; memory contents are retained through reset.
REQ-027 After reset deasserts, the first active edge behaves normally, with no dead cycle.

Structure
REQ-028 Package gowin_sdpb_pkg holds the ADDR_W, DATA_W and DEPTH defaults and the READ_MODE encodings (BYPASS=0, PIPELINE=1).
REQ-029 One sub-module, sdpb_mem_core, holds the storage array, the write port and the rd_q read register; the top level adds the optional oce output register and the reset logic.
REQ-030 The storage array is inferable as block RAM: no asynchronous read, and the array is not reset.

Verification
REQ-031 Write mem[0x0000]=2'b01 and mem[0x7FFF]=2'b11; then read adb=0x0000 and 0x7FFF with ceb=1 -> dout=01 and 11 respectively, one cycle later (READ_MODE=0).
REQ-032 Write 0x1234=2'b10, then on the same edge write 0x1234=2'b01 while reading 0x1234 -> dout=10; re-read on the next cycle -> dout=01.
REQ-033 Hold ceb=0 after a read of 2'b11 while changing adb -> dout stays 11; resetb=1 for one edge -> dout=00.
REQ-034 READ_MODE=1 with oce=1 -> data appears 2 cycles after adb; with oce=0 -> dout holds its previous value.
REQ-035 After memory is written, pulse reset low mid-stream -> dout=0 at once; after release, reading back the earlier addresses returns the written data unchanged.
REQ-036 Fill a 240x128 raster (address {y[6:0],x[7:0]}) with the pattern (x+y)%4 and scan-read all addresses -> every word matches.

Source files
------------

// File: rtl/gowin_sdpb_pkg.sv
// Shared defaults and read-mode encodings for the simple dual-port block RAM.
package gowin_sdpb_pkg;

  localparam int unsigned ADDR_W_DEF = 15;
  localparam int unsigned DATA_W_DEF = 2;
  localparam int unsigned DEPTH_DEF  = 1 << ADDR_W_DEF;

  localparam int unsigned BYPASS   = 0;
  localparam int unsigned PIPELINE = 1;

endpackage

// File: rtl/gowin_sdpb_ram_if.sv
// Port A write / port B read bus of the SDPB RAM.
interface gowin_sdpb_ram_if
  import gowin_sdpb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);
  logic              cea;
  logic              reseta;
  logic [ADDR_W-1:0] ada;
  logic [DATA_W-1:0] din;
  logic              ceb;
  logic              resetb;
  logic              oce;
  logic [ADDR_W-1:0] adb;
  logic [DATA_W-1:0] dout;

  modport master (
    output cea, reseta, ada, din, ceb, resetb, oce, adb,
    input  dout
  );

  modport slave (
    input  cea, reseta, ada, din, ceb, resetb, oce, adb,
    output dout
  );
endinterface

// File: rtl/sdpb_mem_core.sv
// Storage array with synchronous write port and registered read-before-write read port.
module sdpb_mem_core
  import gowin_sdpb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wa_i,
  input  logic [DATA_W-1:0] wd_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] ra_i,
  input  logic              rclr_i,
  output logic [DATA_W-1:0] rd_o
);
  localparam int unsigned Depth = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] rd_q;

  // Array is never reset so it maps onto block RAM; reset only blocks writes.
  always_ff @(posedge clk_i) begin
    if (we_i && rst_ni) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q <= '0;
    end else if (rclr_i) begin
      rd_q <= '0;
    end else if (re_i) begin
      rd_q <= mem_q[ra_i];
    end
  end

  assign rd_o = rd_q;

endmodule

// File: rtl/gowin_sdpb_ram.sv
// Simple dual-port RAM top: memory core plus optional oce-gated output register.
module gowin_sdpb_ram
  import gowin_sdpb_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned READ_MODE = BYPASS
) (
  input  logic               clk,
  input  logic               reset,
  gowin_sdpb_ram_if.slave    bus
);
  logic [DATA_W-1:0] rd;
  logic [DATA_W-1:0] out_d, out_q;
  logic              unused_reseta;

  // Port A reset has no architectural effect on this configuration.
  assign unused_reseta = bus.reseta;

  sdpb_mem_core #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_core (
    .clk_i  (clk),
    .rst_ni (reset),
    .we_i   (bus.cea),
    .wa_i   (bus.ada),
    .wd_i   (bus.din),
    .re_i   (bus.ceb),
    .ra_i   (bus.adb),
    .rclr_i (bus.resetb),
    .rd_o   (rd)
  );

  always_comb begin
    out_d = out_q;
    if (bus.resetb) begin
      out_d = '0;
    end else if (bus.oce) begin
      out_d = rd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign bus.dout = (READ_MODE == PIPELINE) ? out_q : rd;

endmodule

// File: tb/tb_gowin_sdpb_ram.sv
// Directed bench: one bypass and one pipeline instance share the same stimulus.
module tb_gowin_sdpb_ram;
  import gowin_sdpb_pkg::*;

  localparam int unsigned AW = 15;
  localparam int unsigned DW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cea = 1'b0, reseta = 1'b0, ceb = 1'b0, resetb = 1'b0, oce = 1'b0;
  logic [AW-1:0] ada = '0, adb = '0;
  logic [DW-1:0] din = '0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  gowin_sdpb_ram_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
  gowin_sdpb_ram_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  assign bus0.cea = cea;    assign bus1.cea = cea;
  assign bus0.reseta = reseta; assign bus1.reseta = reseta;
  assign bus0.ada = ada;    assign bus1.ada = ada;
  assign bus0.din = din;    assign bus1.din = din;
  assign bus0.ceb = ceb;    assign bus1.ceb = ceb;
  assign bus0.resetb = resetb; assign bus1.resetb = resetb;
  assign bus0.oce = oce;    assign bus1.oce = oce;
  assign bus0.adb = adb;    assign bus1.adb = adb;

  gowin_sdpb_ram #(.ADDR_W(AW), .DATA_W(DW), .READ_MODE(BYPASS)) dut_byp (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  gowin_sdpb_ram #(.ADDR_W(AW), .DATA_W(DW), .READ_MODE(PIPELINE)) dut_pipe (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if (bus0.dout !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_byp: got %b want 00", bus0.dout);
    end
    vectors++;
    if (bus1.dout !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_pipe: got %b want 00", bus1.dout);
    end
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_corners();
    cea = 1'b1; ada = 15'h0000; din = 2'b01;
    tick();
    ada = 15'h7FFF; din = 2'b11;
    tick();
    cea = 1'b0; ceb = 1'b1; adb = 15'h0000;
    tick();
    vectors++;
    if (bus0.dout !== 2'b01) begin
      miscompares++;
      $display("FAIL corner_0000: got %b want 01", bus0.dout);
    end
    adb = 15'h7FFF;
    tick();
    vectors++;
    if (bus0.dout !== 2'b11) begin
      miscompares++;
      $display("FAIL corner_7fff: got %b want 11", bus0.dout);
    end
    ceb = 1'b0;
  endtask

  task automatic test_read_during_write();
    cea = 1'b1; ada = 15'h1234; din = 2'b10;
    tick();
    din = 2'b01; ceb = 1'b1; adb = 15'h1234;
    tick();
    vectors++;
    if (bus0.dout !== 2'b10) begin
      miscompares++;
      $display("FAIL rdw_old: got %b want 10", bus0.dout);
    end
    cea = 1'b0;
    tick();
    vectors++;
    if (bus0.dout !== 2'b01) begin
      miscompares++;
      $display("FAIL rdw_new: got %b want 01", bus0.dout);
    end
    ceb = 1'b0;
  endtask

  task automatic test_hold_and_resetb();
    ceb = 1'b1; adb = 15'h7FFF;
    tick();
    ceb = 1'b0; adb = 15'h0000;
    tick();
    vectors++;
    if (bus0.dout !== 2'b11) begin
      miscompares++;
      $display("FAIL hold_1: got %b want 11", bus0.dout);
    end
    adb = 15'h1234;
    tick();
    vectors++;
    if (bus0.dout !== 2'b11) begin
      miscompares++;
      $display("FAIL hold_2: got %b want 11", bus0.dout);
    end
    resetb = 1'b1; ceb = 1'b1;
    tick();
    vectors++;
    if (bus0.dout !== 2'b00) begin
      miscompares++;
      $display("FAIL resetb_clear: got %b want 00", bus0.dout);
    end
    resetb = 1'b0; ceb = 1'b0;
  endtask

  task automatic test_pipeline();
    cea = 1'b1; ada = 15'h0010; din = 2'b10;
    tick();
    ada = 15'h0011; din = 2'b11;
    tick();
    cea = 1'b0; resetb = 1'b1;
    tick();
    resetb = 1'b0; ceb = 1'b1; oce = 1'b1; adb = 15'h0010;
    tick();
    vectors++;
    if (bus1.dout !== 2'b00) begin
      miscompares++;
      $display("FAIL pipe_lat1: got %b want 00", bus1.dout);
    end
    vectors++;
    if (bus0.dout !== 2'b10) begin
      miscompares++;
      $display("FAIL byp_lat1: got %b want 10", bus0.dout);
    end
    adb = 15'h0011;
    tick();
    vectors++;
    if (bus1.dout !== 2'b10) begin
      miscompares++;
      $display("FAIL pipe_lat2: got %b want 10", bus1.dout);
    end
    oce = 1'b0; adb = 15'h0010;
    tick();
    vectors++;
    if (bus1.dout !== 2'b10) begin
      miscompares++;
      $display("FAIL pipe_oce_hold1: got %b want 10", bus1.dout);
    end
    adb = 15'h0011;
    tick();
    vectors++;
    if (bus1.dout !== 2'b10) begin
      miscompares++;
      $display("FAIL pipe_oce_hold2: got %b want 10", bus1.dout);
    end
    oce = 1'b1;
    tick();
    vectors++;
    if (bus1.dout !== 2'b11) begin
      miscompares++;
      $display("FAIL pipe_oce_resume: got %b want 11", bus1.dout);
    end
    ceb = 1'b0; oce = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [AW-1:0] addrs [3];
    logic [DW-1:0] exp [3];
    addrs[0] = 15'h0000; exp[0] = 2'b01;
    addrs[1] = 15'h7FFF; exp[1] = 2'b11;
    addrs[2] = 15'h1234; exp[2] = 2'b01;
    ceb = 1'b1; oce = 1'b1; adb = 15'h7FFF;
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (bus0.dout !== 2'b00) begin
      miscompares++;
      $display("FAIL async_rst_byp: got %b want 00", bus0.dout);
    end
    vectors++;
    if (bus1.dout !== 2'b00) begin
      miscompares++;
      $display("FAIL async_rst_pipe: got %b want 00", bus1.dout);
    end
    // Writes attempted while in reset must be dropped.
    cea = 1'b1; ada = 15'h0000; din = 2'b10;
    tick();
    tick();
    cea = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      adb = addrs[i];
      tick();
      vectors++;
      if (bus0.dout !== exp[i]) begin
        miscompares++;
        $display("FAIL post_rst_read[%0d]: addr %h got %b want %b",
                 i, addrs[i], bus0.dout, exp[i]);
      end
    end
    ceb = 1'b0; oce = 1'b0;
  endtask

  task automatic test_raster();
    logic [7:0] xv;
    logic [6:0] yv;
    logic [DW-1:0] exp;
    cea = 1'b1;
    for (int y = 0; y < 128; y++) begin
      for (int x = 0; x < 240; x++) begin
        xv = 8'(x); yv = 7'(y);
        ada = {yv, xv};
        din = 2'((x + y) % 4);
        tick();
      end
    end
    cea = 1'b0; ceb = 1'b1;
    for (int y = 0; y < 128; y++) begin
      for (int x = 0; x < 240; x++) begin
        xv = 8'(x); yv = 7'(y);
        adb = {yv, xv};
        exp = 2'((x + y) % 4);
        tick();
        vectors++;
        if (bus0.dout !== exp) begin
          miscompares++;
          $display("FAIL raster: x=%0d y=%0d got %b want %b", x, y, bus0.dout, exp);
        end
      end
    end
    ceb = 1'b0;
  endtask

  initial begin
    test_reset();
    test_corners();
    test_read_during_write();
    test_hold_and_resetb();
    test_pipeline();
    test_async_reset();
    test_raster();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
